// File: rtl/nrdiv_seq.sv
// Sequential unsigned non-restoring divider, one quotient bit per cycle.
// Define NRDIV_REM_EN to add the remainder-correction state and produce the remainder.
module nrdiv_seq #(
    parameter int WIDTH = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div0
);

    localparam int CW = $clog2(WIDTH + 1);

`ifdef NRDIV_REM_EN
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, CORR = 2'd2, DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd3} state_t;
`endif

    state_t           state;
    logic [WIDTH:0]   a;      // signed partial remainder, sign in bit WIDTH
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   d_ext;
    logic [WIDTH:0]   a_shift;
    logic [WIDTH:0]   a_step;
    logic [WIDTH-1:0] q_step;

    assign d_ext = {1'b0, d};

    // The sign of the old partial remainder picks add or subtract for this step.
    always_comb begin
        a_shift = {a[WIDTH-1:0], q[WIDTH-1]};
        if (a[WIDTH])
            a_step = a_shift + d_ext;
        else
            a_step = a_shift - d_ext;
        q_step = {q[WIDTH-2:0], ~a_step[WIDTH]};
    end

`ifdef NRDIV_REM_EN
    logic [WIDTH:0] a_fix;
    assign a_fix = a[WIDTH] ? (a + d_ext) : a;
`endif

    // NOTE: every register here is assigned with <= so that all state advances
    // together on the clock edge regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a         <= '0;
            q         <= '0;
            d         <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div0      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        d        <= divisor;
                        if (divisor == '0) begin
                            quotient  <= '1;
                            remainder <= dividend;
                            div0      <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            a     <= '0;
                            q     <= dividend;
                            cnt   <= CW'(WIDTH);
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    a   <= a_step;
                    q   <= q_step;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
`ifdef NRDIV_REM_EN
                        state <= CORR;
`else
                        quotient  <= q_step;
                        remainder <= '0;
                        div0      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
`endif
                    end
                end
`ifdef NRDIV_REM_EN
                CORR: begin
                    a         <= a_fix;
                    quotient  <= q;
                    remainder <= a_fix[WIDTH-1:0];
                    div0      <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
`endif
                DONE: begin
                    // in_ready rises with the return to IDLE, so the consume edge never accepts.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
